// File: rtl/joy_responder.sv
// joy_responder: SPI slave that stands in for the joystick peripheral, returning a 40-bit position/button packet.
// Define JOY_RESPONDER_LED_EN to decode the master's command byte into LED; otherwise LED is tied to 2'b00.
module joy_responder (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [9:0] X,
    input  logic [9:0] Y,
    input  logic [2:0] BTN,
    output logic [1:0] LED,
    output logic       FRAME_DONE,
    output logic       FRAME_ERR
);
    localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
    logic [2:0]  ss_q, ss_d, sclk_q, sclk_d;
    logic [1:0]  state_q, state_d;
    logic [39:0] tx_q, tx_d, pkt;
    logic [5:0]  cnt_q, cnt_d;
    logic        done_q, done_d, err_q, err_d, pend_q, pend_d;
    logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
    always_comb begin
        ss_d      = {ss_q[1:0], SS};
        sclk_d    = {sclk_q[1:0], SCLK};
        ss_fall   = ss_q[2] & ~ss_q[1];
        ss_rise   = ~ss_q[2] & ss_q[1];
        sclk_rise = ~sclk_q[2] & sclk_q[1];
        sclk_fall = sclk_q[2] & ~sclk_q[1];
        pkt       = {X[7:0], 6'b0, X[9:8], Y[7:0], 6'b0, Y[9:8], 5'b0, BTN};
        state_d   = state_q;
        tx_d      = tx_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        pend_d    = 1'b0;
        case (state_q)
            IDLE: if (ss_fall || pend_q) begin
                state_d = SHIFT;
                tx_d    = pkt;
                cnt_d   = 6'd0;
            end
            SHIFT: if (ss_rise) state_d = DONE;
            else begin
                tx_d  = sclk_fall ? {tx_q[38:0], 1'b0} : tx_q;
                cnt_d = (sclk_rise && cnt_q != 6'd40) ? cnt_q + 6'd1 : cnt_q;
            end
            DONE: begin
                state_d = IDLE;
                pend_d  = ss_fall;
                done_d  = cnt_q == 6'd40;
                err_d   = cnt_q != 6'd40;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ss_q    <= 3'b0;
            sclk_q  <= 3'b0;
            state_q <= IDLE;
            tx_q    <= 40'b0;
            cnt_q   <= 6'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            ss_q    <= ss_d;
            sclk_q  <= sclk_d;
            state_q <= state_d;
            tx_q    <= tx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end
    // the tx MSB is MISO while shifting; load and shift timing give the 3-cycle pin-to-MISO latency
    assign MISO       = (state_q == SHIFT) & tx_q[39];
    assign FRAME_DONE = done_q;
    assign FRAME_ERR  = err_q;
`ifdef JOY_RESPONDER_LED_EN
    logic [1:0] mosi_q, mosi_d, led_q, led_d;
    logic [7:0] rx_q, rx_d;
    always_comb begin
        mosi_d = {mosi_q[0], MOSI};
        rx_d   = (state_q == SHIFT && !ss_rise && sclk_rise && cnt_q < 6'd8) ? {rx_q[6:0], mosi_q[1]} : rx_q;
        led_d  = (state_q == DONE && cnt_q == 6'd40 && rx_q[7]) ? rx_q[1:0] : led_q;
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mosi_q <= 2'b0;
            rx_q   <= 8'b0;
            led_q  <= 2'b0;
        end else begin
            mosi_q <= mosi_d;
            rx_q   <= rx_d;
            led_q  <= led_d;
        end
    end
    assign LED = led_q;
`else
    logic unused_mosi;
    assign unused_mosi = MOSI;
    assign LED = 2'b00;
`endif
endmodule

// File: tb/tb_joy_responder.sv
// tb_joy_responder: scoreboard bench for joy_responder; expected MISO bytes are queued per frame and popped as the master receives them.
module tb_joy_responder;
    logic       clk = 1'b0, rst_n = 1'b0, ss = 1'b1, sclk = 1'b0, mosi = 1'b0;
    logic [9:0] x = 10'h0, y = 10'h0;
    logic [2:0] btn = 3'b0;
    logic       miso, frame_done, frame_err;
    logic [1:0] led;
    logic [1:0] led_exp = 2'b00;
    logic [7:0] sb[$];
    int vectors = 0, miscompares = 0;
    int cyc = 0, n_done = 0, n_err = 0, done_cyc = 0, err_cyc = 0, rise_cyc = 0, exp_done = 0, exp_err = 0;

    joy_responder dut (
        .CLK(clk), .RST_N(rst_n), .SS(ss), .SCLK(sclk), .MOSI(mosi), .MISO(miso),
        .X(x), .Y(y), .BTN(btn), .LED(led), .FRAME_DONE(frame_done), .FRAME_ERR(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (frame_done) begin n_done++; done_cyc = cyc; end
        if (frame_err) begin n_err++; err_cyc = cyc; end
    end

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic frame(input int nbits, input logic [7:0] cmd, input int chg_at, input logic [9:0] newx, input bit lat);
        logic [39:0] pkt;
        logic [7:0]  b;
        pkt = {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, btn};
        for (int i = 0; i < nbits / 8; i++) sb.push_back(i < 5 ? pkt[39 - 8 * i -: 8] : 8'h00);
`ifdef JOY_RESPONDER_LED_EN
        if (nbits >= 40 && cmd[7]) led_exp = cmd[1:0];
`endif
        @(negedge clk);
        ss = 1'b0;
        if (lat) begin
            repeat (2) @(negedge clk);
            chk("miso_pre", miso, 0);
            @(negedge clk);
            chk("miso_first", miso, pkt[39]);
            repeat (7) @(negedge clk);
        end else repeat (10) @(negedge clk);
        b = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 8) ? cmd[7 - (i % 8)] : 1'b1;
            repeat (10) @(negedge clk);
            b = {b[6:0], miso};
            if (i % 8 == 7) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) chk($sformatf("byte%0d", i / 8), b, sb.pop_front());
            end
            sclk = 1'b1;
            if (i == chg_at) x = newx;
            repeat (10) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (10) @(negedge clk);
        ss = 1'b1;
        rise_cyc = cyc;
    endtask

    task automatic post(input int add_done, input int add_err);
        repeat (8) @(negedge clk);
        exp_done += add_done;
        exp_err  += add_err;
        chk("done_cnt", n_done, exp_done);
        chk("err_cnt", n_err, exp_err);
        if (add_done != 0) chk("done_lat", done_cyc - rise_cyc, 4);
        if (add_err != 0) chk("err_lat", err_cyc - rise_cyc, 4);
        chk("led", led, led_exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_miso", miso, 0);
        chk("rst_led", led, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", frame_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        x = 10'h2A5; y = 10'h13C; btn = 3'b101;
        frame(40, 8'h81, -1, 10'h0, 1'b1);
        post(1, 0);
        frame(40, 8'h82, 2, 10'h000, 1'b0);
        post(1, 0);
        frame(40, 8'h83, -1, 10'h0, 1'b0);
        post(1, 0);
        x = 10'h2A5;
        frame(13, 8'h80, -1, 10'h0, 1'b0);
        post(0, 1);
        frame(40, 8'h81, -1, 10'h0, 1'b0);
        post(1, 0);
        frame(40, 8'h03, -1, 10'h0, 1'b0);
        post(1, 0);
        x = 10'h1C3; y = 10'h2E7; btn = 3'b010;
        frame(48, 8'h82, -1, 10'h0, 1'b0);
        post(1, 0);
        frame(40, 8'h81, -1, 10'h0, 1'b0);
        frame(40, 8'h83, -1, 10'h0, 1'b0);
        post(2, 0);
        @(negedge clk);
        ss = 1'b0;
        repeat (10) @(negedge clk);
        sclk = 1'b1;
        repeat (10) @(negedge clk);
        sclk = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        led_exp = 2'b00;
        repeat (3) @(negedge clk);
        chk("midrst_miso", miso, 0);
        chk("midrst_led", led, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (10) @(negedge clk);
            sclk = ~sclk;
            repeat (5) @(negedge clk);
            chk("post_rst_miso", miso, 0);
        end
        ss = 1'b1;
        post(0, 0);
        x = 10'h2A5; y = 10'h13C; btn = 3'b101;
        frame(40, 8'h81, -1, 10'h0, 1'b1);
        post(1, 0);
        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/joy_responder.md
# joy_responder

SPI slave that emulates the joystick peripheral. It answers the joystick SPI master's 5-byte frame with a 40-bit position/button packet and decodes the master's LED command byte. It is used as the far-end model in board-to-board links and as a synthesizable stand-in for the physical peripheral in system simulation. It sits on the 100 MHz fabric clock and oversamples the master's SS/SCLK/MOSI lines.

## Interface
- No parameters.
- CLK  in  1  100 MHz system clock; all logic on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- SS  in  1  slave select from master, active low, asynchronous to CLK.
- SCLK  in  1  SPI clock from master, mode 0 (idle low), asynchronous to CLK.
- MOSI  in  1  command data from master.
- MISO  out  1  response data to master.
- X  in  10  joystick X position, sampled at frame start.
- Y  in  10  joystick Y position, sampled at frame start.
- BTN  in  3  button states, sampled at frame start.
- LED  out  2  last valid LED command.
- FRAME_DONE  out  1  one-cycle pulse after a complete 40-bit frame.
- FRAME_ERR  out  1  one-cycle pulse when SS rises before 40 bits.

## Operation
- SS, SCLK and MOSI pass through 2-flop synchronizers, then a third flop provides edge detection.
  - SS synchronizer flops reset to 0; SCLK flops reset to 0.
  - A reset released while SS is low therefore produces no false fall edge.
- Transmit packet, MSB first: {X[7:0], 6'b0, X[9:8], Y[7:0], 6'b0, Y[9:8], 5'b0, BTN[2:0]}.
- States:
  - IDLE. MISO = 0. A synced SS fall moves to SHIFT. On the same cycle: the packet is loaded into the 40-bit tx register, the bit counter is cleared, and MISO is driven with packet bit 39. A synced SS rise in IDLE is ignored.
  - SHIFT.
    - On a synced SCLK rise: sample MOSI into the 8-bit rx register while counter < 8, then increment the counter (saturating at 40).
    - On a synced SCLK fall: shift the tx register left, fill with 0, and drive MISO with the new MSB.
    - After 40 rises, MISO stays 0 and further edges are ignored.
    - A synced SS rise moves to DONE.
  - DONE. One cycle, then return to IDLE.
    - Counter = 40: pulse FRAME_DONE and commit the LED (see Configuration).
    - Counter < 40: pulse FRAME_ERR; LED is unchanged.
- X/Y/BTN changes during a frame do not affect the packet in flight.
- If SS rise and SCLK fall are detected on the same cycle, SS takes priority.
- Reset asserted mid-frame clears everything immediately. The partial frame is abandoned with no pulses. The next frame starts only on a fresh SS fall.

## Timing
- Reset values: MISO 0, LED 2'b00, FRAME_DONE 0, FRAME_ERR 0, state IDLE, tx/rx/counter 0.
- SS pin fall to MISO valid: 3 CLK cycles.
- SCLK pin fall to MISO update: 3 CLK cycles.
- Master requirements:
  - SCLK high and low phases ≥ 8 CLK cycles.
  - SS fall to first SCLK rise ≥ 8 CLK cycles.
  - Both hold with large margin for a ~33 kHz joystick SCLK.
- SS pin rise to FRAME_DONE/FRAME_ERR pulse: 4 CLK cycles. The pulse is exactly 1 cycle.
- LED updates on the same cycle as FRAME_DONE.
- Back-to-back frames: an SS fall detected in DONE is acted on in the following IDLE cycle, i.e. at most 1 cycle late.

## Configuration
- JOY_RESPONDER_LED_EN defined:
  - In DONE with a complete frame, if rx[7] == 1 (command byte 8'b1xxxxxLL), LED <= rx[1:0].
  - If rx[7] == 0, LED is unchanged.
- Undefined:
  - MOSI is ignored and the rx register is not built.
  - LED is tied to 2'b00.
  - FRAME_DONE/FRAME_ERR behaviour is identical.

## Test plan
- Reset, X=10'h2A5, Y=10'h13C, BTN=3'b101; master sends 5 bytes with command 8'h81 → MISO bytes are A5, 02, 3C, 01, 05. FRAME_DONE pulses once. LED=2'b01 with JOY_RESPONDER_LED_EN defined, 2'b00 without.
- Change X to 10'h000 after the 3rd SCLK rise → current frame still returns A5, 02. The next frame returns 00, 00.
- SS rises after 13 bits → FRAME_ERR pulses once, FRAME_DONE stays 0, LED keeps its previous value, and the next full frame is correct.
- Command 8'h03 (bit7 = 0) → LED unchanged, FRAME_DONE pulses.
- 48 SCLK cycles in one frame → bits 41-48 on MISO are 0, FRAME_DONE pulses once, and the LED comes from the first byte only.
- Hold SS low while RST_N is asserted and released, then toggle SCLK → MISO stays 0 with no pulses. A subsequent SS high→low starts a normal frame.
